// File: rtl/game_status_pkg.sv
// Shared types for the game status monitor: status classes, message selects, FSM states.
package game_status_pkg;

  // Class of a status value, taken from bits [7:6]
  typedef enum logic [1:0] {
    CLS_PLAY = 2'b00,
    CLS_OVER = 2'b01,
    CLS_ERR  = 2'b10,
    CLS_RSVD = 2'b11
  } cls_t;

  localparam logic [5:0] ERR_RSVD_CODE = 6'h3F;

  typedef enum logic [1:0] {
    MSG_NONE = 2'd0,
    MSG_ERR  = 2'd1,
    MSG_WIN  = 2'd2,
    MSG_LOSE = 2'd3
  } msg_t;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    ERR_SHOW = 2'd1,
    OVER     = 2'd2
  } mon_state_t;

  function automatic cls_t status_class(input logic [7:0] s);
    return cls_t'(s[7:6]);
  endfunction

  // Reserved class reports a fixed code; real errors carry their own
  function automatic logic [5:0] status_code(input logic [7:0] s);
    return (s[7:6] == 2'b11) ? ERR_RSVD_CODE : s[5:0];
  endfunction

endpackage

// File: rtl/status_timer.sv
// Terminal-count timer: counts enabled cycles 0..CYCLES-1, restarting at 0 after terminal.
//  clk, rst   clock, async active-high reset
//  i_clr      synchronous clear (priority over enable)
//  i_en       count enable
//  o_done     counter sits at CYCLES-1
module status_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int unsigned CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/game_status_monitor.sv
// Classifies the game status register and drives pulses, error hold and game-over blink.
//  clk, rst            clock, async active-high reset
//  i_current_state     status register value
//  i_clear_err         user acknowledge, ends an error hold early
//  o_status_changed    pulse: status differs from previous sample
//  o_error_pulse       pulse: a new error code entered
//  o_game_over         level: win/lose latched
//  o_winner            1=win 0=lose while game over
//  o_err_code          last error code
//  o_msg_sel           0 none, 1 error, 2 win, 3 lose
//  o_blink             game-over blink
module game_status_monitor
  import game_status_pkg::*;
#(
  parameter int unsigned ERR_HOLD_CYCLES = 50_000_000,
  parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_current_state,
  input  logic       i_clear_err,
  output logic       o_status_changed,
  output logic       o_error_pulse,
  output logic       o_game_over,
  output logic       o_winner,
  output logic [5:0] o_err_code,
  output logic [1:0] o_msg_sel,
  output logic       o_blink
);

  logic [7:0] r_s_q;
  mon_state_t r_state;
  mon_state_t w_state_next;
  cls_t       w_cls;
  logic       w_chg;
  logic       w_new_err;
  logic       w_hold_done;
  logic       w_hold_clr;
  logic       w_hold_en;
  logic       w_blink_done;
  logic       w_blink_en;
  logic       w_winner_next;
  msg_t       w_msg_next;

  assign w_cls     = status_class(i_current_state);
  assign w_chg     = (i_current_state != r_s_q);
  assign w_new_err = w_chg && ((w_cls == CLS_ERR) || (w_cls == CLS_RSVD));

  // Hold restarts on entry and on every new error while showing
  assign w_hold_en  = (r_state == ERR_SHOW);
  assign w_hold_clr = (r_state != ERR_SHOW) || w_new_err;
  // Blink runs only while remaining in game over; any other path clears it
  assign w_blink_en = (r_state == OVER) && (w_state_next == OVER);

  status_timer #(.CYCLES(ERR_HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_hold_clr),
    .i_en   (w_hold_en),
    .o_done (w_hold_done)
  );

  status_timer #(.CYCLES(BLINK_CYCLES)) u_blink_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (!w_blink_en),
    .i_en   (w_blink_en),
    .o_done (w_blink_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= PLAY;
    else     r_state <= w_state_next;
  end

  // Next state and next-cycle display decode; game over has priority everywhere
  always_comb begin
    w_state_next  = r_state;
    w_winner_next = o_winner;
    w_msg_next    = MSG_NONE;
    case (r_state)
      PLAY: begin
        if (w_cls == CLS_OVER) w_state_next = OVER;
        else if (w_new_err)    w_state_next = ERR_SHOW;
      end
      ERR_SHOW: begin
        if (w_cls == CLS_OVER)                w_state_next = OVER;
        else if (w_new_err)                   w_state_next = ERR_SHOW;
        else if (w_hold_done || i_clear_err)  w_state_next = PLAY;
      end
      OVER: begin
        if (w_cls == CLS_PLAY) w_state_next = PLAY;
      end
      default: w_state_next = PLAY;
    endcase

    // Winner tracks the latched bit; error values inside game over leave it alone
    if (w_state_next != OVER)   w_winner_next = 1'b0;
    else if (w_cls == CLS_OVER) w_winner_next = i_current_state[0];

    case (w_state_next)
      ERR_SHOW: w_msg_next = MSG_ERR;
      OVER:     w_msg_next = w_winner_next ? MSG_WIN : MSG_LOSE;
      default:  w_msg_next = MSG_NONE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_q            <= 8'h00;
      o_status_changed <= 1'b0;
      o_error_pulse    <= 1'b0;
      o_game_over      <= 1'b0;
      o_winner         <= 1'b0;
      o_err_code       <= 6'h00;
      o_msg_sel        <= 2'd0;
      o_blink          <= 1'b0;
    end else begin
      r_s_q            <= i_current_state;
      o_status_changed <= w_chg;
      o_error_pulse    <= w_new_err;
      if (w_new_err) o_err_code <= status_code(i_current_state);
      o_game_over      <= (w_state_next == OVER);
      o_winner         <= w_winner_next;
      o_msg_sel        <= 2'(w_msg_next);
      if (w_state_next != OVER)          o_blink <= 1'b0;
      else if (w_blink_en && w_blink_done) o_blink <= ~o_blink;
    end
  end

endmodule
